dvfs_governor: RTL and testbench
================================

# dvfs_governor

Parametrised dynamic voltage/frequency governor for NUM_CORES core domains plus one memory domain. Selects an operating mode from performance request, temperature, battery and per-core idle inputs, with debounce and exit hysteresis. Ramps each rail one code at a time in a safe order: voltage leads frequency going up, frequency leads voltage going down. Sits between the board-level sensor pins and the per-domain regulator/PLL select outputs.

## Interface
- NUM_CORES, 2, number of core domains (1..8)
- VW, 2, voltage code width; VMAX = 2^VW-1
- FW, 3, frequency code width; FMAX = 2^FW-1
- DWELL, 4, consecutive cycles a new mode candidate must hold before the mode changes (>=1)
- STEP_WAIT, 2, settle cycles between rail steps; step tick period = STEP_WAIT+1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- perf_req  in  1  performance request
- temp  in  2  temperature class, 0 = cool .. 3 = critical
- batt  in  2  battery level, 0 = empty .. 3 = full
- core_idle  in  NUM_CORES  per-core idle flag
- vcore  out  NUM_CORES*VW  core voltage codes, core i at [i*VW +: VW]
- fcore  out  NUM_CORES*FW  core frequency codes, core i at [i*FW +: FW]
- vmem  out  VW  memory voltage code
- fmem  out  FW  memory frequency code
- mode  out  3  current mode
- power_save  out  1  high in POWERSAVE or BATTERY
- busy  out  1  any rail not yet at its target

## Operation
- Modes: NORMAL=0, PERFORMANCE=1, POWERSAVE=2, THERMAL=3, BATTERY=4; other encodings are illegal and recover to NORMAL on the next edge.
- Candidate mode, evaluated in priority order:
  - BATTERY if batt<=1.
  - If the current mode is BATTERY, stay BATTERY until batt==3.
  - THERMAL if temp>=2.
  - If the current mode is THERMAL, stay THERMAL until temp==0.
  - PERFORMANCE if perf_req.
  - POWERSAVE if all core_idle bits are set.
  - Otherwise NORMAL.
- Debounce: counter clears when candidate==mode or when the candidate changes. When the candidate differs from mode for DWELL consecutive edges, mode takes the candidate on the DWELL-th edge and the counter clears.
- Targets (v,f) per mode:
  - PERFORMANCE (VMAX,FMAX)
  - NORMAL (VMAX>>1,FMAX>>1)
  - THERMAL (VMAX>>1,FMAX>>2)
  - POWERSAVE (1,1)
  - BATTERY (0,0)
- Per-core gating: in NORMAL or THERMAL, a core with core_idle=1 takes the POWERSAVE target. Memory always takes the mode target.
- Rail step: on each tick, each domain independently applies the first matching rule, otherwise holds:
  - f>tf: f-1
  - else v<tv: v+1
  - else f<tf: f+1
  - else v>tv: v-1
- Invariant: voltage never decreases while f is above its target, and frequency never increases while v is below its target.
- power_save is a registered decode of mode. busy = OR over domains of (v!=tv || f!=tf), combinational.
- Inputs are treated as synchronous to clk; synchronisers are upstream.

## Timing
- Reset values:
  - mode = NORMAL
  - all v/f outputs = 0
  - power_save = 0
  - debounce counter and tick counter = 0
  - busy = 1 immediately after reset, since NORMAL targets are nonzero.
- Tick counter runs freely 0..STEP_WAIT. A tick occurs on the edge where the count equals STEP_WAIT; the first tick is STEP_WAIT+1 edges after reset release.
- Latency from mode change to rail update: the new targets apply from the next tick; at most one code per domain per tick.
- A target change mid-ramp redirects on the next tick; no step is undone or skipped.
- Reset mid-ramp returns all outputs to 0 asynchronously.

## Structure
- Package dvfs_pkg:
  - mode encodings
  - target functions tgt_v(mode,VW) and tgt_f(mode,FW)
  - the POWERSAVE level constant
- Sub-module dvfs_rail_seq: one v/f pair with target inputs, tick input and step rule.
  - Instantiated NUM_CORES+1 times.
  - Exports an at_target flag.
- Top level holds candidate logic, debounce, mode register, tick prescaler and the busy OR.

## Test plan
- Reset release, default params, batt=3, temp=0, perf_req=0, core_idle=0 -> mode NORMAL; each core steps (v,f) as (1,0) then (1,1) then (1,2) then (1,3) on ticks at edges 3, 6, 9, 12; busy falls after the last step.
- perf_req=1 for 3 edges then 0 -> mode unchanged. perf_req held 4 edges -> PERFORMANCE; rails ramp v to 3 before f climbs to 7.
- From PERFORMANCE, batt=1 for 4 edges -> BATTERY, power_save=1; f reaches 0 before v decrements. batt=2 -> stays BATTERY; batt=3 for 4 edges -> NORMAL.
- NORMAL with core_idle=01 -> core0 converges to (1,1), core1 and mem stay at (1,3). core_idle=11 for DWELL edges -> POWERSAVE; all domains at (1,1).
- temp=2 in NORMAL -> THERMAL; cores go to (1,1). temp=1 -> holds THERMAL; temp=0 for 4 edges -> NORMAL.
- rst_n asserted mid-ramp into PERFORMANCE -> all outputs 0 asynchronously, mode NORMAL; after release, ramp restarts from 0.

Source files
------------

// File: rtl/dvfs_pkg.sv
// Shared definitions for the DVFS governor: mode encodings, the POWERSAVE level
// and the per-mode voltage/frequency target functions.
package dvfs_pkg;

    typedef enum logic [2:0] {
        MODE_NORMAL  = 3'd0,
        MODE_PERF    = 3'd1,
        MODE_PSAVE   = 3'd2,
        MODE_THERMAL = 3'd3,
        MODE_BATTERY = 3'd4
    } mode_e;

    localparam int unsigned PS_LEVEL = 1;

    // Illegal encodings fall through to the NORMAL targets.
    function automatic int unsigned tgt_v(input mode_e m, input int unsigned vw);
        int unsigned vmax;
        vmax = (32'd1 << vw) - 32'd1;
        case (m)
            MODE_PERF:    return vmax;
            MODE_THERMAL: return vmax >> 1;
            MODE_PSAVE:   return PS_LEVEL;
            MODE_BATTERY: return 0;
            default:      return vmax >> 1;
        endcase
    endfunction

    function automatic int unsigned tgt_f(input mode_e m, input int unsigned fw);
        int unsigned fmax;
        fmax = (32'd1 << fw) - 32'd1;
        case (m)
            MODE_PERF:    return fmax;
            MODE_THERMAL: return fmax >> 2;
            MODE_PSAVE:   return PS_LEVEL;
            MODE_BATTERY: return 0;
            default:      return fmax >> 1;
        endcase
    endfunction

endpackage

// File: rtl/dvfs_rail_seq.sv
// One voltage/frequency rail pair, stepped one code per tick toward its target
// so that voltage leads frequency on the way up and trails it on the way down.
module dvfs_rail_seq #(
    parameter int unsigned VW = 2,
    parameter int unsigned FW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic [VW-1:0] tv,
    input  logic [FW-1:0] tf,
    output logic [VW-1:0] v,
    output logic [FW-1:0] f,
    output logic          at_target
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            f <= '0;
        end else if (tick) begin
            if (f > tf)
                f <= f - FW'(1);
            else if (v < tv)
                v <= v + VW'(1);
            else if (f < tf)
                f <= f + FW'(1);
            else if (v > tv)
                v <= v - VW'(1);
        end
    end

    assign at_target = (v == tv) && (f == tf);

endmodule

// File: rtl/dvfs_governor.sv
// DVFS governor: debounced mode selection with exit hysteresis, tick prescaler
// and one rail sequencer per core domain plus one for the memory domain.
module dvfs_governor
    import dvfs_pkg::*;
#(
    parameter int unsigned NUM_CORES = 2,
    parameter int unsigned VW        = 2,
    parameter int unsigned FW        = 3,
    parameter int unsigned DWELL     = 4,
    parameter int unsigned STEP_WAIT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    perf_req,
    input  logic [1:0]              temp,
    input  logic [1:0]              batt,
    input  logic [NUM_CORES-1:0]    core_idle,
    output logic [NUM_CORES*VW-1:0] vcore,
    output logic [NUM_CORES*FW-1:0] fcore,
    output logic [VW-1:0]           vmem,
    output logic [FW-1:0]           fmem,
    output logic [2:0]              mode,
    output logic                    power_save,
    output logic                    busy
);

    localparam int unsigned CW = $clog2(DWELL + 1);
    localparam int unsigned TW = (STEP_WAIT > 0) ? $clog2(STEP_WAIT + 1) : 1;

    mode_e          mode_q, mode_d, cand, cand_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]  tcnt_q;
    logic           tick;
    logic           power_save_q;

    logic [VW-1:0]  core_tv [NUM_CORES];
    logic [FW-1:0]  core_tf [NUM_CORES];
    logic [VW-1:0]  mem_tv;
    logic [FW-1:0]  mem_tf;
    logic [NUM_CORES-1:0] core_at;
    logic           mem_at;

    assign tick = (tcnt_q == TW'(STEP_WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tcnt_q <= '0;
        else if (tick)
            tcnt_q <= '0;
        else
            tcnt_q <= tcnt_q + TW'(1);
    end

    // Hold clauses keep BATTERY/THERMAL until the input fully recovers.
    always_comb begin
        cand = MODE_NORMAL;
        if (batt <= 2'd1)
            cand = MODE_BATTERY;
        else if (mode_q == MODE_BATTERY && batt != 2'd3)
            cand = MODE_BATTERY;
        else if (temp >= 2'd2)
            cand = MODE_THERMAL;
        else if (mode_q == MODE_THERMAL && temp != 2'd0)
            cand = MODE_THERMAL;
        else if (perf_req)
            cand = MODE_PERF;
        else if (&core_idle)
            cand = MODE_PSAVE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= MODE_NORMAL;
            cand_q       <= MODE_NORMAL;
            cnt_q        <= '0;
            power_save_q <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            cand_q       <= cand;
            cnt_q        <= cnt_d;
            power_save_q <= (mode_d == MODE_PSAVE) || (mode_d == MODE_BATTERY);
        end
    end

    // A streak continues only while the same differing candidate persists;
    // cnt_q is zero whenever the previous candidate matched the mode.
    always_comb begin
        int unsigned streak;
        logic        legal;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        streak = 1;
        case (mode_q)
            MODE_NORMAL, MODE_PERF, MODE_PSAVE, MODE_THERMAL, MODE_BATTERY: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            mode_d = MODE_NORMAL;
            cnt_d  = '0;
        end else if (cand == mode_q) begin
            cnt_d = '0;
        end else begin
            if (cand == cand_q)
                streak = 32'(cnt_q) + 32'd1;
            if (streak >= DWELL) begin
                mode_d = cand;
                cnt_d  = '0;
            end else begin
                cnt_d = CW'(streak);
            end
        end
    end

    always_comb begin
        logic gate;
        gate   = (mode_q == MODE_NORMAL) || (mode_q == MODE_THERMAL);
        mem_tv = VW'(tgt_v(mode_q, VW));
        mem_tf = FW'(tgt_f(mode_q, FW));
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (gate && core_idle[i]) begin
                core_tv[i] = VW'(tgt_v(MODE_PSAVE, VW));
                core_tf[i] = FW'(tgt_f(MODE_PSAVE, FW));
            end else begin
                core_tv[i] = mem_tv;
                core_tf[i] = mem_tf;
            end
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        dvfs_rail_seq #(.VW(VW), .FW(FW)) u_rail (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .tv        (core_tv[g]),
            .tf        (core_tf[g]),
            .v         (vcore[g*VW +: VW]),
            .f         (fcore[g*FW +: FW]),
            .at_target (core_at[g])
        );
    end

    dvfs_rail_seq #(.VW(VW), .FW(FW)) u_mem_rail (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .tv        (mem_tv),
        .tf        (mem_tf),
        .v         (vmem),
        .f         (fmem),
        .at_target (mem_at)
    );

    assign mode       = mode_q;
    assign power_save = power_save_q;
    assign busy       = !(&core_at && mem_at);

endmodule

// File: tb/tb_dvfs_governor.sv
// Scoreboard bench for dvfs_governor: a per-edge reference model pushes expected
// outputs, and a negedge monitor pops and compares them.
module tb_dvfs_governor;

    localparam int NC    = 2;
    localparam int VW    = 2;
    localparam int FW    = 3;
    localparam int DWELL = 4;
    localparam int SW    = 2;
    localparam int VMAX  = 3;
    localparam int FMAX  = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              perf_req = 1'b0;
    logic [1:0]        temp = 2'd0;
    logic [1:0]        batt = 2'd3;
    logic [NC-1:0]     core_idle = '0;
    logic [NC*VW-1:0]  vcore;
    logic [NC*FW-1:0]  fcore;
    logic [VW-1:0]     vmem;
    logic [FW-1:0]     fmem;
    logic [2:0]        mode;
    logic              power_save;
    logic              busy;

    dvfs_governor #(
        .NUM_CORES (NC),
        .VW        (VW),
        .FW        (FW),
        .DWELL     (DWELL),
        .STEP_WAIT (SW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .perf_req   (perf_req),
        .temp       (temp),
        .batt       (batt),
        .core_idle  (core_idle),
        .vcore      (vcore),
        .fcore      (fcore),
        .vmem       (vmem),
        .fmem       (fmem),
        .mode       (mode),
        .power_save (power_save),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int vc;
        int fc;
        int vm;
        int fm;
        int ps;
        int busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state; domain index NC is the memory rail.
    int m_mode, m_run_cand, m_run_len, m_tcnt;
    int m_v[NC+1];
    int m_f[NC+1];

    function automatic int tv_of(input int md);
        case (md)
            1: return VMAX;
            2: return 1;
            4: return 0;
            default: return VMAX / 2;
        endcase
    endfunction

    function automatic int tf_of(input int md);
        case (md)
            1: return FMAX;
            2: return 1;
            3: return FMAX / 4;
            4: return 0;
            default: return FMAX / 2;
        endcase
    endfunction

    function automatic int eff_mode(input int d, input int md);
        if (d < NC && (md == 0 || md == 3) && core_idle[d]) return 2;
        return md;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_run_cand = 0; m_run_len = 0; m_tcnt = 0;
        for (int d = 0; d <= NC; d++) begin
            m_v[d] = 0;
            m_f[d] = 0;
        end
    endtask

    task automatic model_step();
        int cand;
        if (m_tcnt == SW) begin
            m_tcnt = 0;
            for (int d = 0; d <= NC; d++) begin
                int tv, tf;
                tv = tv_of(eff_mode(d, m_mode));
                tf = tf_of(eff_mode(d, m_mode));
                if (m_f[d] > tf)      m_f[d]--;
                else if (m_v[d] < tv) m_v[d]++;
                else if (m_f[d] < tf) m_f[d]++;
                else if (m_v[d] > tv) m_v[d]--;
            end
        end else begin
            m_tcnt++;
        end
        if (batt <= 1)                       cand = 4;
        else if (m_mode == 4 && batt != 3)   cand = 4;
        else if (temp >= 2)                  cand = 3;
        else if (m_mode == 3 && temp != 0)   cand = 3;
        else if (perf_req)                   cand = 1;
        else if (core_idle == '1)            cand = 2;
        else                                 cand = 0;
        if (cand == m_mode) begin
            m_run_len = 0;
        end else begin
            if (m_run_len > 0 && cand == m_run_cand) m_run_len++;
            else begin
                m_run_cand = cand;
                m_run_len  = 1;
            end
            if (m_run_len >= DWELL) begin
                m_mode    = cand;
                m_run_len = 0;
            end
        end
    endtask

    function automatic exp_t make_exp();
        exp_t e;
        e.vc = 0; e.fc = 0; e.busy = 0;
        for (int d = 0; d < NC; d++) begin
            e.vc += m_v[d] * (1 << (d * VW));
            e.fc += m_f[d] * (1 << (d * FW));
        end
        for (int d = 0; d <= NC; d++)
            if (m_v[d] != tv_of(eff_mode(d, m_mode)) || m_f[d] != tf_of(eff_mode(d, m_mode)))
                e.busy = 1;
        e.mode = m_mode;
        e.vm   = m_v[NC];
        e.fm   = m_f[NC];
        e.ps   = (m_mode == 2 || m_mode == 4) ? 1 : 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk("mode",       int'(mode),       e.mode);
                chk("vcore",      int'(vcore),      e.vc);
                chk("fcore",      int'(fcore),      e.fc);
                chk("vmem",       int'(vmem),       e.vm);
                chk("fmem",       int'(fmem),       e.fm);
                chk("power_save", int'(power_save), e.ps);
                chk("busy",       int'(busy),       e.busy);
            end
        end
    end

    // Entered between a negedge and the next posedge; returns at negedge+1.
    task automatic drive(input bit p, input int t, input int b, input int idl, input int n);
        perf_req  = p;
        temp      = 2'(t);
        batt      = 2'(b);
        core_idle = NC'(idl);
        repeat (n) begin
            @(posedge clk);
            model_step();
            q.push_back(make_exp());
        end
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mode"},  int'(mode),       0);
        chk({tag, "_vcore"}, int'(vcore),      0);
        chk({tag, "_fcore"}, int'(fcore),      0);
        chk({tag, "_vmem"},  int'(vmem),       0);
        chk({tag, "_fmem"},  int'(fmem),       0);
        chk({tag, "_ps"},    int'(power_save), 0);
        chk({tag, "_busy"},  int'(busy),       1);
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_reset_state("reset");
        #9;
        rst_n = 1'b1;

        drive(0, 0, 3, 0, 15);
        drive(1, 0, 3, 0, 3);
        drive(0, 0, 3, 0, 6);
        drive(1, 0, 3, 0, 40);
        drive(1, 0, 1, 0, 40);
        drive(1, 0, 2, 0, 10);
        drive(0, 0, 3, 0, 40);
        drive(0, 0, 3, 1, 30);
        drive(0, 0, 3, 3, 30);
        drive(0, 0, 3, 0, 30);
        drive(0, 2, 3, 0, 30);
        drive(0, 1, 3, 0, 10);
        drive(0, 0, 3, 0, 30);
        drive(1, 0, 3, 0, 20);
        async_reset();
        drive(0, 0, 3, 0, 40);

        for (int k = 0; k < 60; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, (1 << NC) - 1), $urandom_range(1, 10));
            if (k == 30) async_reset();
        end
        drive(0, 0, 3, 0, 40);

        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
